// File: rtl/sgen_cordic_seq.sv
// -----------------------------------------------------------------------------
// sgen_cordic_seq
//
// Sequential full-circle CORDIC engine: one sample in flight at a time, one
// micro-rotation per enabled clock. Works in rotation mode (drive z to 0) or
// vectoring mode (drive y to 0). A quadrant pre-rotation on capture gives
// the full +/-pi range, and an optional 1/K_N gain stage with saturation
// follows the iterations.
//
// Ports
//   i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//   i_ena             clock enable; everything freezes while low
//   i_valid, o_ready  input handshake (o_ready = IDLE and i_ena)
//   i_x, i_y, i_z     signed input vector and angle (full circle = 2^gp_z_width)
//   o_valid, i_ready  output handshake; the result is held until accepted
//   o_x, o_y          saturated signed result
//   o_z               residual (rotation) or accumulated (vectoring) angle,
//                     wrapped modulo 2*pi
//   o_sat             o_x or o_y was clamped for the current result
// -----------------------------------------------------------------------------
module sgen_cordic_seq #(
    parameter bit gp_mode_rot_vec = 1'b1,
    parameter int gp_nr_iter      = 16,
    parameter int gp_xy_width     = 16,
    parameter int gp_z_width      = 16,
    parameter bit gp_gain_comp    = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_ena,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic signed [gp_xy_width-1:0] i_x,
    input  logic signed [gp_xy_width-1:0] i_y,
    input  logic signed [gp_z_width-1:0]  i_z,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic signed [gp_xy_width-1:0] o_x,
    output logic signed [gp_xy_width-1:0] o_y,
    output logic signed [gp_z_width-1:0]  o_z,
    output logic                          o_sat
);

    localparam int  XW   = gp_xy_width;
    localparam int  ZW   = gp_z_width;
    localparam int  N    = gp_nr_iter;
    localparam int  CW   = $clog2(N);
    localparam int  IW   = XW + 2 + CW;   // x/y datapath: guard for gain and pre-rotation growth
    localparam int  ZIW  = ZW + 1;        // z datapath
    localparam int  PW   = IW + XW + 1;   // gain product width
    localparam real PI_R = 3.14159265358979323846;

    // ---------------------------------------------------------------------
    // Elaboration-time constants
    // ---------------------------------------------------------------------
    function automatic real neg_pow2(input int e);
        real p;
        p = 1.0;
        for (int k = 0; k < e; k++) p = p / 2.0;
        return p;
    endfunction

    function automatic real pos_pow2(input int e);
        real p;
        p = 1.0;
        for (int k = 0; k < e; k++) p = p * 2.0;
        return p;
    endfunction

    // atan(2^-i) in angle LSBs, rounded to nearest (all entries are positive)
    function automatic int atan_lsb(input int i);
        real ang;
        ang = $atan(neg_pow2(i)) * pos_pow2(ZW) / (2.0 * PI_R);
        return $rtoi(ang + 0.5);
    endfunction

    // round(2^(XW-1) / K_N), K_N = prod sqrt(1 + 2^-2i)
    function automatic int kc_lsb();
        real k;
        k = 1.0;
        for (int i = 0; i < N; i++) k = k * $sqrt(1.0 + neg_pow2(2 * i));
        return $rtoi(pos_pow2(XW - 1) / k + 0.5);
    endfunction

    localparam logic signed [ZIW-1:0] HALF_PI = {2'b00, 1'b1, {(ZW-2){1'b0}}};
    localparam logic signed [PW-1:0]  SAT_MAX = (PW'(1) <<< (XW - 1)) - PW'(1);
    localparam logic signed [PW-1:0]  SAT_MIN = -(PW'(1) <<< (XW - 1));

    logic signed [ZIW-1:0] atan_tab [N];
    for (genvar gi = 0; gi < N; gi++) begin : g_atan
        localparam int ATAN_V = atan_lsb(gi);
        assign atan_tab[gi] = ZIW'(ATAN_V);
    end

    // Returns {clamped, value}
    function automatic logic [XW:0] saturate(input logic signed [PW-1:0] v);
        logic [XW:0] r;
        if (v > SAT_MAX)      r = {1'b1, SAT_MAX[XW-1:0]};
        else if (v < SAT_MIN) r = {1'b1, SAT_MIN[XW-1:0]};
        else                  r = {1'b0, v[XW-1:0]};
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_GAIN, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic signed [IW-1:0]   x_q, x_d, y_q, y_d;
    logic signed [ZIW-1:0]  z_q, z_d;
    logic [CW-1:0]          iter_q, iter_d;
    logic signed [XW-1:0]   o_x_q, o_x_d, o_y_q, o_y_d;
    logic signed [ZW-1:0]   o_z_q, o_z_d;
    logic                   o_sat_q, o_sat_d;
    logic                   o_valid_q, o_valid_d;

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    logic signed [IW-1:0]  in_x, in_y;
    logic signed [ZIW-1:0] in_z;
    assign in_x = IW'(i_x);
    assign in_y = IW'(i_y);
    assign in_z = ZIW'(i_z);

    // Gain stage: x*Kc and y*Kc, rounded half-up back to the x/y scale
    logic signed [PW-1:0] gx_full, gy_full;
    if (gp_gain_comp) begin : g_gain
        localparam logic signed [PW-1:0] KC  = PW'(kc_lsb());
        localparam logic signed [PW-1:0] RND = PW'(1) <<< (XW - 2);
        logic signed [PW-1:0] px, py;
        assign px      = PW'(x_q) * KC;
        assign py      = PW'(y_q) * KC;
        assign gx_full = (px + RND) >>> (XW - 1);
        assign gy_full = (py + RND) >>> (XW - 1);
    end else begin : g_raw
        assign gx_full = PW'(x_q);
        assign gy_full = PW'(y_q);
    end

    logic [XW:0]          sat_x, sat_y;
    logic signed [IW-1:0] x_sh, y_sh;
    logic                 d_pos;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        iter_d    = iter_q;
        o_x_d     = o_x_q;
        o_y_d     = o_y_q;
        o_z_d     = o_z_q;
        o_sat_d   = o_sat_q;
        o_valid_d = o_valid_q;

        sat_x = saturate(gx_full);
        sat_y = saturate(gy_full);
        x_sh  = x_q >>> iter_q;
        y_sh  = y_q >>> iter_q;
        // d = +1: rotation when z >= 0, vectoring when y < 0
        d_pos = gp_mode_rot_vec ? !z_q[ZIW-1] : y_q[IW-1];

        if (i_ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        x_d     = in_x;
                        y_d     = in_y;
                        z_d     = in_z;
                        iter_d  = '0;
                        state_d = ST_ITER;
                        // Fold the input into the right half-plane / +-pi/2 range
                        if (gp_mode_rot_vec) begin
                            if (i_z[ZW-1:ZW-2] == 2'b01) begin
                                x_d = -in_y;
                                y_d = in_x;
                                z_d = in_z - HALF_PI;
                            end else if (i_z[ZW-1:ZW-2] == 2'b10) begin
                                x_d = in_y;
                                y_d = -in_x;
                                z_d = in_z + HALF_PI;
                            end
                        end else if (i_x[XW-1]) begin
                            if (!i_y[XW-1]) begin
                                x_d = in_y;
                                y_d = -in_x;
                                z_d = in_z + HALF_PI;
                            end else begin
                                x_d = -in_y;
                                y_d = in_x;
                                z_d = in_z - HALF_PI;
                            end
                        end
                    end
                end
                ST_ITER: begin
                    if (d_pos) begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atan_tab[iter_q];
                    end else begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atan_tab[iter_q];
                    end
                    iter_d = iter_q + CW'(1);
                    if (iter_q == CW'(N - 1)) state_d = ST_GAIN;
                end
                ST_GAIN: begin
                    o_x_d     = sat_x[XW-1:0];
                    o_y_d     = sat_y[XW-1:0];
                    o_sat_d   = sat_x[XW] | sat_y[XW];
                    o_z_d     = z_q[ZW-1:0];   // wraps modulo 2*pi
                    o_valid_d = 1'b1;
                    state_d   = ST_DONE;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            iter_q    <= '0;
            o_x_q     <= '0;
            o_y_q     <= '0;
            o_z_q     <= '0;
            o_sat_q   <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            iter_q    <= iter_d;
            o_x_q     <= o_x_d;
            o_y_q     <= o_y_d;
            o_z_q     <= o_z_d;
            o_sat_q   <= o_sat_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE) && i_ena;
    assign o_valid = o_valid_q;
    assign o_x     = o_x_q;
    assign o_y     = o_y_q;
    assign o_z     = o_z_q;
    assign o_sat   = o_sat_q;

endmodule
